// File: rtl/run_control_if.sv
// Front-panel run/step bus: raw buttons, halt-stage feedback and breakpoint
// inputs toward the controller; halt/step strobes and status back out.
interface run_control_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 8
);
  logic             run_btn;
  logic             step_btn;
  logic             h;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_arm;
  logic             halt;
  logic             en_l;
  logic [CNT_W-1:0] step_cnt;
  logic             bp_hit;

  modport master (
    output run_btn, step_btn, h, pc, bp_addr, bp_arm,
    input  halt, en_l, step_cnt, bp_hit
  );

  modport slave (
    input  run_btn, step_btn, h, pc, bp_addr, bp_arm,
    output halt, en_l, step_cnt, bp_hit
  );
endinterface

// File: rtl/run_control.sv
// Run/step controller: debounced RUN/STEP buttons, HALT level and EN_L step strobe.
// Optional PC breakpoint halt is built when RUN_CONTROL_BREAKPOINT_EN is defined.
module run_control #(
  parameter int DEB_CYCLES = 16,
  parameter int STEP_LOW   = 2,
  parameter int PC_W       = 8,
  parameter int CNT_W      = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  run_control_if.slave bus
);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SW = (STEP_LOW > 1) ? $clog2(STEP_LOW) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_HALTED,
    S_STEP_PULSE,
    S_STEP_WAIT
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_press;
  logic       w_run_press;
  logic       w_step_press;
  logic       w_bp_match;

  assign w_raw        = {bus.step_btn, bus.run_btn};
  assign w_run_press  = w_press[0];
  assign w_step_press = w_press[1];

  // Index 0 = RUN button, index 1 = STEP button.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_press;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
        r_deb   <= 1'b1;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
        r_press <= 1'b0;
        if (r_sync2 == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == DW'(DEB_CYCLES - 1)) begin
          // This edge is the DEB_CYCLES-th consecutive disagreement.
          r_deb   <= r_sync2;
          r_cnt   <= '0;
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end
    end

    assign w_press[gi] = r_press;
  end

`ifdef RUN_CONTROL_BREAKPOINT_EN
  assign w_bp_match = bus.bp_arm && (bus.pc == bus.bp_addr);
`else
  logic [PC_W-1:0] w_unused_pc;
  logic            w_unused_arm;
  assign w_unused_pc  = bus.pc ^ bus.bp_addr;
  assign w_unused_arm = bus.bp_arm;
  assign w_bp_match   = 1'b0;
`endif

  state_t           r_state;
  logic             r_halt;
  logic             r_en_l;
  logic             r_bp_hit;
  logic             r_wait_armed;
  logic [SW-1:0]    r_low_cnt;
  logic [CNT_W-1:0] r_step_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_HALTED;
      r_halt       <= 1'b1;
      r_en_l       <= 1'b1;
      r_bp_hit     <= 1'b0;
      r_wait_armed <= 1'b0;
      r_low_cnt    <= '0;
      r_step_cnt   <= '0;
    end else begin
      case (r_state)
        S_HALTED: begin
          if (w_run_press) begin
            r_state  <= S_RUN;
            r_halt   <= 1'b0;
            r_bp_hit <= 1'b0;
          end else if (w_step_press) begin
            r_state   <= S_STEP_PULSE;
            r_en_l    <= 1'b0;
            r_low_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_bp_match) begin
            r_state  <= S_HALTED;
            r_halt   <= 1'b1;
            r_bp_hit <= 1'b1;
          end else if (w_run_press) begin
            r_state <= S_HALTED;
            r_halt  <= 1'b1;
          end
        end
        S_STEP_PULSE: begin
          if (r_low_cnt == SW'(STEP_LOW - 1)) begin
            r_state      <= S_STEP_WAIT;
            r_en_l       <= 1'b1;
            r_wait_armed <= 1'b0;
          end else begin
            r_low_cnt <= r_low_cnt + SW'(1);
          end
        end
        S_STEP_WAIT: begin
          // The first H sample after entry may predate the stage reacting; skip it.
          r_wait_armed <= 1'b1;
          if (r_wait_armed && bus.h) begin
            r_state    <= S_HALTED;
            r_step_cnt <= r_step_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_HALTED;
          r_halt  <= 1'b1;
          r_en_l  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.halt     = r_halt;
  assign bus.en_l     = r_en_l;
  assign bus.step_cnt = r_step_cnt;
  assign bus.bp_hit   = r_bp_hit;
endmodule

// File: doc/run_control.md
Name: run_control

Overview:
- Front-panel run/step controller.
- Debounces the raw RUN and STEP push-buttons and tracks run/halt mode.
- Drives the HALT level and the active-low EN_L step strobe consumed by the processor halt stage.
- Watches the stage's H (stall) output to confirm each single step has completed, and can halt on a PC breakpoint.

Parameters:
- DEB_CYCLES, 16, consecutive stable cycles required before a debounced button changes state (min 1).
- STEP_LOW, 2, cycles EN_L is held low per step request (min 1).
- PC_W, 8, width of PC and BP_ADDR.
- CNT_W, 8, width of STEP_CNT.

Ports:
- CLK  input  1  system clock, all logic on posedge.
- RST  input  1  synchronous reset, active-high.
- RUN_BTN  input  1  raw run/halt toggle button, active-low, asynchronous.
- STEP_BTN  input  1  raw single-step button, active-low, asynchronous.
- H  input  1  halt-stage stall output, 1 = processor stalled.
- PC  input  PC_W  current program counter.
- BP_ADDR  input  PC_W  breakpoint address.
- BP_ARM  input  1  breakpoint enable.
- HALT  output  1  halt request, 1 = halted mode.
- EN_L  output  1  step strobe, active-low.
- STEP_CNT  output  CNT_W  completed single steps since reset.
- BP_HIT  output  1  sticky breakpoint-halt flag.

Behaviour:
- All outputs are registered. Reset (RST=1 at posedge) values:
  - state HALTED, HALT=1, EN_L=1, STEP_CNT=0, BP_HIT=0.
  - Synchronizer and debounced registers = 1; debounce counters = 0.
- Per button, synchronizer: 2-FF chain.
- Per button, debouncer:
  - Counter increments while the synced value differs from the debounced value.
  - Counter clears whenever they are equal.
  - When the counter reaches DEB_CYCLES, the debounced value takes the synced value and the counter clears.
- Press: one-cycle internal pulse on a debounced 1->0 transition.
  - Latency from a clean raw falling edge to the press pulse is 2+DEB_CYCLES cycles.
  - Release (0->1) generates nothing.
  - Glitches shorter than DEB_CYCLES cycles are ignored.
- FSM states: RUN, HALTED, STEP_PULSE, STEP_WAIT.
- HALTED: HALT=1, EN_L=1.
  - run press -> RUN; BP_HIT cleared.
  - else step press -> STEP_PULSE.
  - Run press and step press in the same cycle: run wins.
- RUN: HALT=0, EN_L=1.
  - run press -> HALTED.
  - Breakpoint match (see Optional Feature) -> HALTED.
  - Step presses are ignored.
- STEP_PULSE: HALT=1, EN_L=0 for exactly STEP_LOW cycles, then -> STEP_WAIT.
- STEP_WAIT: HALT=1, EN_L=1.
  - Remains until H=1 is sampled on a cycle at least one cycle after entry.
  - On that sample: STEP_CNT increments and state -> HALTED.
  - If H never returns to 1, stays indefinitely; only RST exits.
- All presses arriving in STEP_PULSE or STEP_WAIT are discarded, not queued.
- STEP_CNT wraps from 2^CNT_W-1 to 0 and is never cleared except by RST.
- RST mid-step: EN_L returns to 1 and state to HALTED on the same edge; no count increment.

Optional Feature:
- Macro: RUN_CONTROL_BREAKPOINT_EN.
- Defined:
  - In RUN, when BP_ARM=1 and PC==BP_ADDR at a posedge, next cycle state=HALTED, HALT=1, BP_HIT=1.
  - BP_HIT stays 1 until the next run press or RST.
  - The match has priority over a simultaneous run press; the result is HALTED with BP_HIT=1.
  - While HALTED on the breakpoint PC, a run press leaves RUN for at least one cycle before the match is re-evaluated.
- Undefined: PC, BP_ADDR and BP_ARM are ignored; BP_HIT is constant 0; ports remain present.

Test Plan:
1. Reset then idle buttons high for 50 cycles -> HALT=1, EN_L=1, STEP_CNT=0, BP_HIT=0 throughout.
2. DEB_CYCLES=4: RUN_BTN low for 10 cycles -> HALT falls 0 exactly 7 cycles (2 sync + 4 debounce + 1 output register) after the raw edge. RUN_BTN glitch low for 3 cycles -> no change.
3. HALTED, STEP_LOW=2: clean step press -> EN_L low for exactly 2 cycles. Model H drops then rises 3 cycles later -> STEP_CNT=1, state HALTED. Second step press during STEP_WAIT -> ignored, STEP_CNT stays 1.
4. CNT_W=2: perform 5 steps -> STEP_CNT sequence 1,2,3,0,1.
5. RUN_BTN and STEP_BTN pressed with identical timing while HALTED -> RUN entered, EN_L never low.
6. Macro defined, BP_ADDR=0x3C, BP_ARM=1, RUN, PC ramps 0x38->0x3C -> HALT=1 and BP_HIT=1 the cycle after PC=0x3C. Run press -> BP_HIT=0, HALT=0. Macro undefined, same stimulus -> HALT stays 0.
